// File: rtl/seq_pkg.sv
// Shared constants for the sequence generator / detector path.
package seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [15:0] SEQ_INIT_DEF = 16'b0000_1101_1001_0101;

    // Pattern the downstream detector searches for; its bench uses this constant too.
    localparam logic [4:0]  DET_TARGET   = 5'b10110;

endpackage

// File: rtl/seq_gen_tick_gen.sv
// Bit-period divider: tick is high in the last of every CLK_DIV enabled cycles.
module tick_gen
    import seq_pkg::*;
#(
    parameter int CLK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == TC);

    // Wrapping at terminal count restarts the period for the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern source: shifts the stored pattern out MSB-first, one bit per CLK_DIV clocks.
module seq_gen
    import seq_pkg::*;
#(
    parameter int                 SEQ_LEN  = 16,
    parameter logic [SEQ_LEN-1:0] SEQ_INIT = SEQ_INIT_DEF,
    parameter int                 CLK_DIV  = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       load,
    input  logic [SEQ_LEN-1:0]         load_data,
    input  logic                       loop_en,
    output logic                       seq_bit,
    output logic                       bit_valid,
    output logic [$clog2(SEQ_LEN)-1:0] bit_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int            IW   = $clog2(SEQ_LEN);
    localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

    state_t             state, state_nx;
    logic [SEQ_LEN-1:0] pattern, pattern_nx;
    logic               seq_bit_nx, bit_valid_nx, busy_nx, done_nx;
    logic [IW-1:0]      bit_idx_nx;
    logic               tick, tick_clear, tick_en;

    assign tick_clear = (state == ST_IDLE) || stop;
    assign tick_en    = (state == ST_RUN);

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pattern   <= SEQ_INIT;
            seq_bit   <= 1'b0;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            pattern   <= pattern_nx;
            seq_bit   <= seq_bit_nx;
            bit_valid <= bit_valid_nx;
            bit_idx   <= bit_idx_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pattern_nx   = pattern;
        seq_bit_nx   = seq_bit;
        bit_valid_nx = 1'b0;
        bit_idx_nx   = bit_idx;
        busy_nx      = busy;
        done_nx      = 1'b0;

        case (state)
            ST_IDLE: begin
                seq_bit_nx = 1'b0;
                busy_nx    = 1'b0;
                bit_idx_nx = '0;
                if (load) begin
                    pattern_nx = load_data;
                end
                // A load in the same cycle as start supplies the first bit.
                if (start && !stop) begin
                    state_nx     = ST_RUN;
                    seq_bit_nx   = pattern_nx[SEQ_LEN-1];
                    bit_valid_nx = 1'b1;
                    busy_nx      = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_nx   = ST_IDLE;
                    seq_bit_nx = 1'b0;
                    busy_nx    = 1'b0;
                    bit_idx_nx = '0;
                end else if (tick) begin
                    if (bit_idx == LAST) begin
                        done_nx = 1'b1;
                        if (loop_en) begin
                            bit_idx_nx   = '0;
                            seq_bit_nx   = pattern[SEQ_LEN-1];
                            bit_valid_nx = 1'b1;
                        end else begin
                            state_nx   = ST_IDLE;
                            seq_bit_nx = 1'b0;
                            busy_nx    = 1'b0;
                            bit_idx_nx = '0;
                        end
                    end else begin
                        bit_idx_nx   = bit_idx + 1'b1;
                        seq_bit_nx   = pattern[LAST - bit_idx_nx];
                        bit_valid_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with CLK_DIV=4, one with CLK_DIV=1.
module tb_seq_gen;
    import seq_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        a_start, a_stop, a_load, a_loop_en;
    logic [15:0] a_load_data;
    logic        a_seq_bit, a_bit_valid, a_busy, a_done;
    logic [3:0]  a_bit_idx;

    logic        b_start, b_stop, b_load, b_loop_en;
    logic [15:0] b_load_data;
    logic        b_seq_bit, b_bit_valid, b_busy, b_done;
    logic [3:0]  b_bit_idx;

    int          n_chk;
    int          n_pass;
    logic [4:0]  det;
    logic        hit;
    int          hits;

    localparam logic [15:0] DEF_PAT = 16'b0000110110010101;

    seq_gen #(.SEQ_LEN(16), .CLK_DIV(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (a_start),
        .stop      (a_stop),
        .load      (a_load),
        .load_data (a_load_data),
        .loop_en   (a_loop_en),
        .seq_bit   (a_seq_bit),
        .bit_valid (a_bit_valid),
        .bit_idx   (a_bit_idx),
        .busy      (a_busy),
        .done      (a_done)
    );

    seq_gen #(.SEQ_LEN(16), .CLK_DIV(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .stop      (b_stop),
        .load      (b_load),
        .load_data (b_load_data),
        .loop_en   (b_loop_en),
        .seq_bit   (b_seq_bit),
        .bit_valid (b_bit_valid),
        .bit_idx   (b_bit_idx),
        .busy      (b_busy),
        .done      (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the start edge; checks n_cyc cycles, optional load pulse at load_at.
    task automatic pass_a(input logic [15:0] pat, input int n_cyc, input int load_at);
        for (int k = 0; k < n_cyc; k++) begin
            check("a_bit",   {31'd0, a_seq_bit},   {31'd0, pat[15 - k/4]});
            check("a_valid", {31'd0, a_bit_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
            check("a_idx",   {28'd0, a_bit_idx},   k / 4);
            check("a_busy",  {31'd0, a_busy},      32'd1);
            check("a_done",  {31'd0, a_done},      32'd0);
            a_load      = (k == load_at);
            a_load_data = 16'hFFFF;
            step();
        end
        a_load = 1'b0;
    endtask

    task automatic a_idle_checks(input string tag);
        check({tag, "_bit"},   {31'd0, a_seq_bit},   32'd0);
        check({tag, "_valid"}, {31'd0, a_bit_valid}, 32'd0);
        check({tag, "_idx"},   {28'd0, a_bit_idx},   32'd0);
        check({tag, "_busy"},  {31'd0, a_busy},      32'd0);
        check({tag, "_done"},  {31'd0, a_done},      32'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; hits = 0; det = '0; hit = 1'b0;
        rst_n = 1'b0;
        a_start = 0; a_stop = 0; a_load = 0; a_loop_en = 0; a_load_data = '0;
        b_start = 0; b_stop = 0; b_load = 0; b_loop_en = 0; b_load_data = '0;

        repeat (2) step();
        a_idle_checks("rst");
        check("rst_b_busy", {31'd0, b_busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // Default pattern, single pass
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(DEF_PAT, 64, -1);
        check("def_done",  {31'd0, a_done},      32'd1);
        check("def_busy",  {31'd0, a_busy},      32'd0);
        check("def_bit",   {31'd0, a_seq_bit},   32'd0);
        check("def_valid", {31'd0, a_bit_valid}, 32'd0);
        step();
        check("def_done_clr", {31'd0, a_done}, 32'd0);

        // Load in IDLE, then run; a load mid-run must be ignored
        a_load = 1'b1; a_load_data = 16'hA5F0; step(); a_load = 1'b0;
        check("load_nostart", {31'd0, a_busy}, 32'd0);
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(16'hA5F0, 64, 10);
        check("a5f0_done", {31'd0, a_done}, 32'd1);
        step();
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(16'hA5F0, 64, -1);
        step();

        // Load and start in the same cycle
        a_load = 1'b1; a_load_data = 16'h3C5A; a_start = 1'b1; step();
        a_load = 1'b0; a_start = 1'b0;
        pass_a(16'h3C5A, 64, -1);
        step();

        // Abort at bit 7
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(16'h3C5A, 28, -1);
        check("abort_idx7", {28'd0, a_bit_idx}, 32'd7);
        a_stop = 1'b1; step(); a_stop = 1'b0;
        a_idle_checks("abort");
        step();
        check("abort_nodone", {31'd0, a_done}, 32'd0);

        // start with stop in IDLE stays idle
        a_start = 1'b1; a_stop = 1'b1; step(); a_start = 1'b0; a_stop = 1'b0;
        check("ss_busy",  {31'd0, a_busy},      32'd0);
        check("ss_valid", {31'd0, a_bit_valid}, 32'd0);
        step();
        check("ss_busy2", {31'd0, a_busy}, 32'd0);

        // stop at last-bit terminal count suppresses done
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(16'h3C5A, 63, -1);
        check("last_idx15", {28'd0, a_bit_idx}, 32'd15);
        a_stop = 1'b1; step(); a_stop = 1'b0;
        a_idle_checks("laststop");
        step();
        check("laststop_done2", {31'd0, a_done}, 32'd0);

        // Reset mid-run reverts to the default pattern
        a_load = 1'b1; a_load_data = 16'h1234; step(); a_load = 1'b0;
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(16'h1234, 36, -1);
        check("mid_idx9", {28'd0, a_bit_idx}, 32'd9);
        #2 rst_n = 1'b0;
        #1 a_idle_checks("midrst");
        #2 rst_n = 1'b1;
        step();
        a_start = 1'b1; step(); a_start = 1'b0;
        pass_a(DEF_PAT, 64, -1);
        check("postrst_done", {31'd0, a_done}, 32'd1);
        step();

        // Loop mode at one bit per cycle, ended by stop on a last bit
        b_loop_en = 1'b1; b_start = 1'b1; step(); b_start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            check("b_bit",   {31'd0, b_seq_bit},   {31'd0, DEF_PAT[15 - (k % 16)]});
            check("b_valid", {31'd0, b_bit_valid}, 32'd1);
            check("b_busy",  {31'd0, b_busy},      32'd1);
            check("b_idx",   {28'd0, b_bit_idx},   k % 16);
            check("b_done",  {31'd0, b_done},      (k % 16 == 0 && k > 0) ? 32'd1 : 32'd0);
            b_stop = (k == 47);
            step();
        end
        b_stop = 1'b0;
        check("bstop_busy", {31'd0, b_busy},    32'd0);
        check("bstop_done", {31'd0, b_done},    32'd0);
        check("bstop_bit",  {31'd0, b_seq_bit}, 32'd0);
        step();

        // Detector integration: target seen once, after bit index 9
        b_loop_en = 1'b0; b_start = 1'b1; step(); b_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (b_bit_valid) det = {det[3:0], b_seq_bit};
            hit = (det == DET_TARGET);
            if (hit) hits++;
            check("det_hit", {31'd0, hit}, (k == 9) ? 32'd1 : 32'd0);
            step();
        end
        check("det_done",  {31'd0, b_done}, 32'd1);
        check("det_busy",  {31'd0, b_busy}, 32'd0);
        check("det_count", hits,            32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
